// File: rtl/debug_unit_tx_pkg.sv
// Shared constants for the MIPS debug unit: latch widths, command codes,
// frame geometry and the command FSM state encoding.
package debug_unit_tx_pkg;

    localparam int NB_IF_ID  = 64;
    localparam int NB_ID_EX  = 192;
    localparam int NB_EX_MEM = 128;
    localparam int NB_MEM_WB = 64;
    localparam int NB_DATA   = 8;
    localparam int NB_CYCLES = 32;

    localparam logic [7:0] HEADER   = 8'hA5;
    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    localparam int NB_SNAP   = NB_CYCLES + NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB;
    localparam int FRAME_LEN = 1 + NB_SNAP / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_SNAP,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic int frame_len(input int nb_snap, input int nb_data);
        return 1 + nb_snap / nb_data;
    endfunction

endpackage

// File: rtl/debug_unit_tx_if.sv
// UART-side byte channel of the debug unit: command bytes in, frame bytes out.
interface debug_unit_tx_if #(
    parameter int NB_DATA = 8
) ();
    logic [NB_DATA-1:0] rx_data;
    logic               rx_valid;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               tx_done;

    // master: the debug unit; slave: the UART RX/TX pair
    modport master (
        input  rx_data,
        input  rx_valid,
        input  tx_done,
        output tx_data,
        output tx_start
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output tx_done,
        input  tx_data,
        input  tx_start
    );
endinterface

// File: rtl/debug_tx_serializer.sv
// Holds the frozen snapshot and walks it out one byte at a time, header first,
// MSB byte first, advancing on each acknowledged byte.
module debug_tx_serializer #(
    parameter int                 NB_SNAP = 480,
    parameter int                 NB_DATA = 8,
    parameter logic [NB_DATA-1:0] HEADER  = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [NB_SNAP-1:0] i_snapshot,
    input  logic               i_send,
    input  logic               i_ack,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_frame_done
);
    localparam int FRAME_LEN = 1 + NB_SNAP / NB_DATA;
    localparam int NB_FRAME  = FRAME_LEN * NB_DATA;
    localparam int NB_IDX    = $clog2(FRAME_LEN);

    logic [NB_SNAP-1:0]  snap_q;
    logic [NB_IDX-1:0]   idx_q;
    logic [NB_DATA-1:0]  tx_data_q;
    logic [NB_FRAME-1:0] frame_bits;
    logic                last_byte;

    function automatic logic [NB_DATA-1:0] byte_sel(input logic [NB_FRAME-1:0] frame,
                                                    input logic [NB_IDX-1:0]   k);
        logic [NB_FRAME-1:0] sh;
        sh = frame >> (NB_DATA * (FRAME_LEN - 1 - int'(k)));
        return sh[NB_DATA-1:0];
    endfunction

    assign frame_bits   = {HEADER, snap_q};
    assign last_byte    = (idx_q == NB_IDX'(FRAME_LEN - 1));
    assign o_frame_done = i_ack && last_byte;
    assign o_tx_start   = i_send;
    assign o_tx_data    = tx_data_q;

    // The outgoing byte is registered one step ahead so it is already valid
    // in the cycle that raises tx_start, and stays put until the next ack.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            snap_q    <= '0;
            idx_q     <= '0;
            tx_data_q <= '0;
        end else if (i_load) begin
            snap_q    <= i_snapshot;
            idx_q     <= '0;
            tx_data_q <= HEADER;
        end else if (i_ack && !last_byte) begin
            idx_q     <= idx_q + NB_IDX'(1);
            tx_data_q <= byte_sel(frame_bits, idx_q + NB_IDX'(1));
        end
    end

endmodule

// File: rtl/debug_unit_tx.sv
// MIPS debug unit: decodes UART commands, gates the pipeline clock-enable,
// counts executed cycles and ships a snapshot frame of all latch buses.
module debug_unit_tx
    import debug_unit_tx_pkg::*;
#(
    parameter int NB_IF_ID_P  = NB_IF_ID,
    parameter int NB_ID_EX_P  = NB_ID_EX,
    parameter int NB_EX_MEM_P = NB_EX_MEM,
    parameter int NB_MEM_WB_P = NB_MEM_WB,
    parameter int NB_CYCLES_P = NB_CYCLES
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    debug_unit_tx_if.master        uart,
    input  logic                   i_halt,
    input  logic [NB_IF_ID_P-1:0]  i_if_id,
    input  logic [NB_ID_EX_P-1:0]  i_id_ex,
    input  logic [NB_EX_MEM_P-1:0] i_ex_mem,
    input  logic [NB_MEM_WB_P-1:0] i_mem_wb,
    output logic                   o_mips_enable,
    output logic                   o_dump_done,
    output logic                   o_busy
);
    localparam int NB_SNAP_P = NB_CYCLES_P + NB_IF_ID_P + NB_ID_EX_P + NB_EX_MEM_P + NB_MEM_WB_P;

    state_t                 state_q, state_d;
    logic [NB_CYCLES_P-1:0] cycles_q;
    logic                   frame_done;
    logic                   ser_ack;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (uart.rx_valid) begin
                    if (uart.rx_data == CMD_RUN)       state_d = ST_RUN;
                    else if (uart.rx_data == CMD_STEP) state_d = ST_STEP;
                    else if (uart.rx_data == CMD_DUMP) state_d = ST_SNAP;
                end
            end
            ST_RUN:  if (i_halt) state_d = ST_SNAP;
            ST_STEP: state_d = ST_SNAP;
            ST_SNAP: state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (frame_done)        state_d = ST_DONE;
                else if (uart.tx_done) state_d = ST_SEND;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Halt gates enable in the same cycle so the halting cycle is never counted.
    assign o_mips_enable = ((state_q == ST_RUN) && !i_halt) || (state_q == ST_STEP);
    assign o_dump_done   = (state_q == ST_DONE);
    assign o_busy        = (state_q != ST_IDLE);
    assign ser_ack       = (state_q == ST_WAIT) && uart.tx_done;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)             cycles_q <= '0;
        else if (o_mips_enable) cycles_q <= cycles_q + NB_CYCLES_P'(1);
    end

    debug_tx_serializer #(
        .NB_SNAP (NB_SNAP_P),
        .NB_DATA (NB_DATA),
        .HEADER  (HEADER)
    ) u_serializer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (state_q == ST_SNAP),
        .i_snapshot   ({cycles_q, i_if_id, i_id_ex, i_ex_mem, i_mem_wb}),
        .i_send       (state_q == ST_SEND),
        .i_ack        (ser_ack),
        .o_tx_data    (uart.tx_data),
        .o_tx_start   (uart.tx_start),
        .o_frame_done (frame_done)
    );

endmodule

// File: tb/tb_debug_unit_tx.sv
// Bench for debug_unit_tx: a UART responder collects frames and compares them
// with frames assembled from the command history and bus values.
module tb_debug_unit_tx;
    import debug_unit_tx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic halt;
    logic [NB_IF_ID-1:0]  if_id;
    logic [NB_ID_EX-1:0]  id_ex;
    logic [NB_EX_MEM-1:0] ex_mem;
    logic [NB_MEM_WB-1:0] mem_wb;
    logic enable, dump_done, busy;

    int vectors = 0;
    int miscompares = 0;
    logic [NB_CYCLES-1:0] model_cnt;
    logic [7:0] got [FRAME_LEN];
    int got_n;
    int en_seen;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    debug_unit_tx_if #(.NB_DATA(NB_DATA)) uart ();

    debug_unit_tx dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .uart          (uart),
        .i_halt        (halt),
        .i_if_id       (if_id),
        .i_id_ex       (id_ex),
        .i_ex_mem      (ex_mem),
        .i_mem_wb      (mem_wb),
        .o_mips_enable (enable),
        .o_dump_done   (dump_done),
        .o_busy        (busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [191:0] rnd_wide();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic randomize_buses();
        logic [191:0] t;
        t = rnd_wide(); if_id  = t[NB_IF_ID-1:0];
        t = rnd_wide(); id_ex  = t[NB_ID_EX-1:0];
        t = rnd_wide(); ex_mem = t[NB_EX_MEM-1:0];
        t = rnd_wide(); mem_wb = t[NB_MEM_WB-1:0];
    endtask

    task automatic push_field(input logic [191:0] v, input int nbits);
        for (int b = nbits / 8 - 1; b >= 0; b--) exp_q.push_back(v[b*8 +: 8]);
    endtask

    // Expected frame for a snapshot taken with counter value cnt and the present buses.
    task automatic build_expected(input logic [NB_CYCLES-1:0] cnt);
        exp_q.delete();
        exp_q.push_back(HEADER);
        push_field(192'(cnt), NB_CYCLES);
        push_field(192'(if_id), NB_IF_ID);
        push_field(192'(id_ex), NB_ID_EX);
        push_field(192'(ex_mem), NB_EX_MEM);
        push_field(192'(mem_wb), NB_MEM_WB);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        uart.rx_data  = c;
        uart.rx_valid = 1'b1;
        @(posedge clk); #1;
        uart.rx_valid = 1'b0;
    endtask

    // UART responder: serves nbytes bytes with random done latency.
    task automatic collect_frame(input int nbytes, input int dmin, input int dmax, input bit perturb);
        int guard;
        int d;
        logic [7:0] held;
        got_n = 0;
        en_seen = 0;
        guard = 0;
        while (uart.tx_start !== 1'b1 && guard < 2000) begin
            if (enable === 1'b1) en_seen++;
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) begin
            vectors++; miscompares++;
            $display("FAIL first_tx_start: no start within 2000 cycles");
            return;
        end
        for (int i = 0; i < nbytes; i++) begin
            got[i] = uart.tx_data;
            got_n++;
            held = uart.tx_data;
            d = $urandom_range(dmax, dmin);
            for (int k = 0; k < d; k++) begin
                @(posedge clk); #1;
                uart.rx_valid = 1'b0;
                vectors++;
                if (uart.tx_data !== held || uart.tx_start !== 1'b0 || enable !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wait_stable byte %0d: data=%h start=%b en=%b, required data=%h start=0 en=0",
                             i, uart.tx_data, uart.tx_start, enable, held);
                end
                if (perturb) begin
                    randomize_buses();
                    if ($urandom_range(7, 0) == 0) begin
                        uart.rx_data  = CMD_STEP;
                        uart.rx_valid = 1'b1;
                    end
                end
            end
            uart.rx_valid = 1'b0;
            uart.tx_done  = 1'b1;
            @(posedge clk); #1;
            uart.tx_done  = 1'b0;
            if (i == FRAME_LEN - 1) begin
                vectors++;
                if (dump_done !== 1'b1 || uart.tx_start !== 1'b0) begin
                    miscompares++;
                    $display("FAIL dump_done_pulse: dump_done=%b start=%b, required 1/0", dump_done, uart.tx_start);
                end
            end else if (i < nbytes - 1) begin
                vectors++;
                if (uart.tx_start !== 1'b1) begin
                    miscompares++;
                    $display("FAIL next_start byte %0d: start=%b, required 1", i + 1, uart.tx_start);
                    return;
                end
            end
        end
        if (nbytes == FRAME_LEN) begin
            @(posedge clk); #1;
            vectors++;
            if (dump_done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL after_done: dump_done=%b busy=%b, required 0/0", dump_done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (busy !== 1'b0 || enable !== 1'b0 || uart.tx_start !== 1'b0 ||
                dump_done !== 1'b0 || uart.tx_data !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_idle: busy=%b en=%b start=%b done=%b data=%h, required all 0",
                         busy, enable, uart.tx_start, dump_done, uart.tx_data);
            end
        end
        // An unknown byte must not leave IDLE.
        send_cmd(8'h41);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_cmd_ignored: busy=%b, required 0", busy);
        end
        model_cnt = '0;
    endtask

    task automatic test_single_step();
        randomize_buses();
        if_id = 64'h0000_0004_2002_0005;
        build_expected(model_cnt + 1);
        send_cmd(CMD_STEP);
        collect_frame(FRAME_LEN, 1, 3, 1'b0);
        model_cnt = model_cnt + 1;
        vectors++;
        if (en_seen != 1) begin
            miscompares++;
            $display("FAIL step_enable_cycles: got %0d, required 1", en_seen);
        end
        vectors++;
        if (got_n != FRAME_LEN) begin
            miscompares++;
            $display("FAIL step_frame_len: got %0d, required %0d", got_n, FRAME_LEN);
        end
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL step_byte %0d: got %h, required %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_dump_only();
        randomize_buses();
        build_expected(model_cnt);
        send_cmd(CMD_DUMP);
        collect_frame(FRAME_LEN, 1, 4, 1'b0);
        vectors++;
        if (en_seen != 0) begin
            miscompares++;
            $display("FAIL dump_enable_cycles: got %0d, required 0", en_seen);
        end
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL dump_byte %0d: got %h, required %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_run_to_halt(input int n);
        int en;
        int guard;
        randomize_buses();
        build_expected(model_cnt + NB_CYCLES'(n));
        halt = (n == 0);
        send_cmd(CMD_RUN);
        en = 0;
        guard = 0;
        while (guard < 1000) begin
            if (en >= n) halt = 1'b1;
            #1;
            if (uart.tx_start === 1'b1) break;
            if (enable === 1'b1) en++;
            @(posedge clk); #1;
            guard++;
        end
        collect_frame(FRAME_LEN, 1, 2, 1'b0);
        halt = 1'b0;
        model_cnt = model_cnt + NB_CYCLES'(n);
        vectors++;
        if (en != n || guard >= 1000) begin
            miscompares++;
            $display("FAIL run_enable_cycles: got %0d, required %0d", en, n);
        end
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL run_byte %0d (n=%0d): got %h, required %h", k, n, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        randomize_buses();
        build_expected(model_cnt + 1);
        send_cmd(CMD_STEP);
        collect_frame(FRAME_LEN, 5, 200, 1'b1);
        model_cnt = model_cnt + 1;
        vectors++;
        if (en_seen != 1) begin
            miscompares++;
            $display("FAIL bp_enable_cycles: got %0d, required 1", en_seen);
        end
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL bp_byte %0d: got %h, required %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        randomize_buses();
        build_expected(model_cnt);
        send_cmd(CMD_DUMP);
        collect_frame(20, 1, 2, 1'b0);
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL partial_byte %0d: got %h, required %h", k, got[k], exp_q[k]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || enable !== 1'b0 || uart.tx_start !== 1'b0 ||
            dump_done !== 1'b0 || uart.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: busy=%b en=%b start=%b done=%b data=%h, required all 0",
                     busy, enable, uart.tx_start, dump_done, uart.tx_data);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_cnt = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (dump_done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: done=%b busy=%b, required 0/0", dump_done, busy);
            end
        end
        randomize_buses();
        build_expected(model_cnt);
        send_cmd(CMD_DUMP);
        collect_frame(FRAME_LEN, 1, 3, 1'b0);
        vectors++;
        if (got_n != FRAME_LEN) begin
            miscompares++;
            $display("FAIL post_reset_frame_len: got %0d, required %0d", got_n, FRAME_LEN);
        end
        for (int k = 0; k < got_n; k++) begin
            vectors++;
            if (got[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL post_reset_byte %0d: got %h, required %h", k, got[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        halt          = 1'b0;
        uart.rx_data  = '0;
        uart.rx_valid = 1'b0;
        uart.tx_done  = 1'b0;
        if_id = '0; id_ex = '0; ex_mem = '0; mem_wb = '0;
        model_cnt = '0;
        #2;
        test_reset();
        test_single_step();
        test_dump_only();
        test_reset_mid_frame();
        test_run_to_halt(10);
        test_run_to_halt(int'($urandom_range(40, 1)));
        test_run_to_halt(0);
        test_back_pressure();
        test_dump_only();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
